chacha20_word_packer: RTL and testbench
=======================================

Name: chacha20_word_packer

Overview:
Byte-stream to 32-bit word packer. This is the transmit end of the plaintext/ciphertext word stream consumed by chacha20_encrypt and chacha20_decrypt. It accepts a byte stream with valid/ready/last and packs bytes MSB-first into 32-bit words, matching the {b0,b1,b2,b3} word packing used by the cipher cores. It emits words with valid/ready/last plus a byte-keep mask for the final partial word, and signals completion with the total byte count.

Parameters:
PAD_BYTE, 8'h00, fill value for unused byte lanes of a final partial word
CNT_W, 32, width of byte_count

Ports:
clk  input  1  system clock
rst_n  input  1  reset
start  input  1  one-cycle pulse; arms packer for a new message
in_data  input  8  input byte
in_valid  input  1  in_data valid
in_last  input  1  marks final byte of message
in_ready  output  1  packer accepts byte this cycle
word_data  output  32  packed word; first byte in [31:24]
word_valid  output  1  word_data valid
word_last  output  1  final word of message
word_keep  output  4  valid byte lanes, MSB-aligned (1111/1110/1100/1000)
word_ready  input  1  downstream accepts word
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when final word has been accepted downstream
byte_count  output  CNT_W  bytes accepted in current/last message

Behaviour:
- Single clock domain: clk. rst_n is asynchronous, active-low.
- Reset values: in_ready=0, word_valid=0, word_last=0, word_keep=0, word_data=0, busy=0, done=0, byte_count=0. The FIFO and accumulator are emptied.
- Handshakes: a byte transfers on in_valid&&in_ready at a rising edge; a word transfers on word_valid&&word_ready. Once word_valid is high, word_data/last/keep are held stable until the word is accepted.
- FSM states:
  - IDLE: in_ready=0. start -> ACCEPT; byte_count cleared and accumulator cleared on the same edge.
  - ACCEPT: in_ready = (fifo_count<2). On accepted byte: byte_count+1, byte stored in lane (3 - lane_idx), lane_idx+1. Accepted in_last -> DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty after the last word pops -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in ACCEPT and DRAIN.
- Word push:
  - On the 4th accepted byte, or on any byte with in_last, the word {acc, this byte, PAD_BYTE fill} is pushed into a 2-entry output FIFO with keep and last. lane_idx resets to 0.
  - Latency: the word is visible on word_valid the cycle after the completing byte is accepted.
- keep encoding for a last word of k bytes: k=4 -> 1111, 3 -> 1110, 2 -> 1100, 1 -> 1000. Non-last words are always 1111.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- in_ready depends only on state and registered fifo_count, never combinationally on word_ready.
- A start pulse outside IDLE is ignored, with no effect on the stream in flight.
- in_valid outside ACCEPT is ignored. in_last with no byte transfer has no effect.
- An empty message (zero bytes) is not representable; the block waits in ACCEPT indefinitely.
- byte_count wraps modulo 2^CNT_W, with no flag. It holds its final value after done until the next accepted start.
- Reset mid-operation returns immediately to the reset values. Any partial word and FIFO contents are discarded.

Decomposition:
- Shared package chacha20_pkg:
  - WORD_W=32, BYTES_PER_WORD=4
  - state enum for IDLE/ACCEPT/DRAIN/DONE
  - keep constants KEEP_1..KEEP_4
  - function mapping byte count to keep mask
- Sub-module chacha20_skid_fifo: 2-entry FIFO, 37 bits wide (data+last+keep), valid/ready both sides, exports count. The same FIFO is reusable on the cipher output side.

Test Plan:
1. start, then 24 bytes "Very very secret message" with in_last on byte 24, word_ready=1 -> words 0x56657279, 0x20766572, 0x79207365, 0x63726574, 0x206d6573, 0x73616765; keep=1111 on all; word_last only on the 6th; done pulse one cycle after the 6th word accepted; byte_count=24.
2. "Hi!" (0x48,0x69,0x21, last on 0x21) -> single word 0x48692100, keep=1110, last=1. A second run with PAD_BYTE=8'hFF -> 0x486921FF. A single byte 0x41 with last -> 0x41000000, keep=1000.
3. Backpressure: word_ready=0, stream 12 bytes -> in_ready drops after byte 8 (FIFO holds 2 words). Raising word_ready resumes the stream. Output order is exact, with no lost or duplicated word.
4. Random word_ready toggling at ~50% over a 37-byte message -> 10 words, last word keep=1000, and word_data stable whenever word_valid&&!word_ready.
5. Reset mid-operation: assert rst_n low after 5 bytes -> all outputs at reset values asynchronously. After release, a new start plus "Hi!" yields exactly 0x48692100 with byte_count=3.
6. A start pulse asserted during ACCEPT of scenario 1 -> ignored; identical word output and byte_count=24.

Source files
------------

// File: rtl/chacha20_pkg.sv
// Shared types and helpers for the ChaCha20 word-stream blocks.
package chacha20_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DRAIN,
    ST_DONE
  } pack_state_t;

  // Byte-keep masks, MSB-aligned: first byte of the word lives in lane 3
  localparam logic [3:0] KEEP_1 = 4'b1000;
  localparam logic [3:0] KEEP_2 = 4'b1100;
  localparam logic [3:0] KEEP_3 = 4'b1110;
  localparam logic [3:0] KEEP_4 = 4'b1111;

  // Map number of valid bytes in a word (1..4) to its keep mask
  function automatic logic [3:0] keep_for(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return KEEP_1;
      3'd2:    return KEEP_2;
      3'd3:    return KEEP_3;
      default: return KEEP_4;
    endcase
  endfunction

endpackage

// File: rtl/chacha20_skid_fifo.sv
// Two-entry valid/ready FIFO; head entry always sits in 'head' so the
// output is a plain register and is stable while the consumer stalls.
module chacha20_skid_fifo #(
  parameter int unsigned W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head;

  // Storage and occupancy; a pop from a full FIFO shifts tail into head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        if (count == 2'd2)
          head <= tail;
        else if (push)
          head <= in_data;
      end else if (push) begin
        if (count == 2'd0)
          head <= in_data;
        else
          tail <= in_data;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/chacha20_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words with keep/last and
// reports message completion and total byte count.
module chacha20_word_packer
  import chacha20_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      word_data,
  output logic             word_valid,
  output logic             word_last,
  output logic [3:0]       word_keep,
  input  logic             word_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] byte_count
);

  localparam int unsigned FIFO_W = WORD_W + 1 + BYTES_PER_WORD;

  pack_state_t               state;
  pack_state_t               state_nxt;
  logic [1:0]                lane_idx;
  logic [23:0]               acc;
  logic                      in_fire;
  logic                      word_push;
  logic                      word_pop;
  logic                      fifo_in_ready;
  logic [1:0]                fifo_count;
  logic [WORD_W-1:0]         push_word;
  logic [BYTES_PER_WORD-1:0] push_keep;
  logic [FIFO_W-1:0]         fifo_in;
  logic [FIFO_W-1:0]         fifo_out;

  assign in_fire   = in_valid && in_ready;
  assign word_push = in_fire && ((lane_idx == 2'd3) || in_last);
  assign word_pop  = word_valid && word_ready;
  assign push_keep = keep_for({1'b0, lane_idx} + 3'd1);
  assign fifo_in   = {push_word, in_last, push_keep};
  assign {word_data, word_last, word_keep} = fifo_out;

  // Assemble the outgoing word from held lanes, the current byte and padding
  always_comb begin
    case (lane_idx)
      2'd0:    push_word = {in_data, PAD_BYTE, PAD_BYTE, PAD_BYTE};
      2'd1:    push_word = {acc[23:16], in_data, PAD_BYTE, PAD_BYTE};
      2'd2:    push_word = {acc[23:8], in_data, PAD_BYTE};
      default: push_word = {acc, in_data};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs; in_ready uses registered FIFO occupancy only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        busy     = 1'b1;
        in_ready = fifo_in_ready;
        if (in_fire && in_last)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && word_pop))
          state_nxt = ST_DONE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Lane accumulator and byte counter; lane 3 never needs storing because
  // the fourth byte always completes and pushes the word directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx   <= '0;
      acc        <= '0;
      byte_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      lane_idx   <= '0;
      acc        <= '0;
      byte_count <= '0;
    end else if (in_fire) begin
      byte_count <= byte_count + CNT_W'(1);
      if (word_push) begin
        lane_idx <= '0;
        acc      <= '0;
      end else begin
        lane_idx <= lane_idx + 2'd1;
        case (lane_idx)
          2'd0:    acc[23:16] <= in_data;
          2'd1:    acc[15:8]  <= in_data;
          default: acc[7:0]   <= in_data;
        endcase
      end
    end
  end

  chacha20_skid_fifo #(
    .W(FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (fifo_in),
    .in_valid (word_push),
    .in_ready (fifo_in_ready),
    .out_data (fifo_out),
    .out_valid(word_valid),
    .out_ready(word_ready),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_chacha20_word_packer.sv
// Directed bench for chacha20_word_packer (default padding and 8'hFF padding).
module tb_chacha20_word_packer;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wrec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [31:0]      word_data;
  logic             word_valid;
  logic             word_last;
  logic [3:0]       word_keep;
  logic             word_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] byte_count;

  logic             in_ready_ff;
  logic [31:0]      word_data_ff;
  logic             word_valid_ff;
  logic             word_last_ff;
  logic [3:0]       word_keep_ff;
  logic             busy_ff;
  logic             done_ff;
  logic [CNT_W-1:0] byte_count_ff;

  logic ready_val = 1'b1;
  logic rand_mode = 1'b0;
  logic rnd_bit   = 1'b0;

  int checks = 0;
  int errors = 0;

  wrec_t       wq[$];
  logic [31:0] ffq[$];
  logic [7:0]  msg[64];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_acc_cyc = 0;
  int unsigned stab_err = 0;
  int unsigned stall_cnt = 0;
  logic        hold_pending = 1'b0;
  wrec_t       held;

  assign word_ready = rand_mode ? rnd_bit : ready_val;

  always #5 clk = ~clk;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  chacha20_word_packer #(
    .PAD_BYTE(8'h00),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_last (word_last),
    .word_keep (word_keep),
    .word_ready(word_ready),
    .busy      (busy),
    .done      (done),
    .byte_count(byte_count)
  );

  chacha20_word_packer #(
    .PAD_BYTE(8'hFF),
    .CNT_W   (CNT_W)
  ) dut_ff (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_ff),
    .word_data (word_data_ff),
    .word_valid(word_valid_ff),
    .word_last (word_last_ff),
    .word_keep (word_keep_ff),
    .word_ready(word_ready),
    .busy      (busy_ff),
    .done      (done_ff),
    .byte_count(byte_count_ff)
  );

  // Capture accepted words, done pulses and held-word stability at each edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (word_valid && word_ready) begin
        wq.push_back(wrec_t'({word_data, word_keep, word_last}));
        if (word_last) last_acc_cyc = cyc;
      end
      if (word_valid_ff && word_ready) ffq.push_back(word_data_ff);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (hold_pending && (!word_valid || ({word_data, word_keep, word_last} !== held)))
        stab_err = stab_err + 1;
      hold_pending = word_valid && !word_ready;
      if (hold_pending) stall_cnt = stall_cnt + 1;
      held = wrec_t'({word_data, word_keep, word_last});
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic pulse_start);
    int unsigned n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    start    = pulse_start;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL byte_accept_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_msg(input int n, input int start_at);
    for (int i = 0; i < n; i++)
      send_byte(msg[i], (i == n - 1), (i == start_at));
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned base;
    int unsigned n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL done_timeout done pulses=%0d required %0d", done_cnt - base, 1);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, word_valid, word_last, word_keep, word_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b l=%b k=%b d=%h busy=%b done=%b required all 0",
               in_ready, word_valid, word_last, word_keep, word_data, busy, done);
    end
    checks++;
    if (byte_count !== '0) begin
      errors++;
      $display("FAIL reset_byte_count got %0d required 0", byte_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, done, word_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b done=%b v=%b required 0",
               in_ready, busy, done, word_valid);
    end
  endtask

  task automatic test_secret_message(input int start_at);
    string       s;
    logic [31:0] exp[6];
    int unsigned base;
    s   = "Very very secret message";
    exp = '{32'h56657279, 32'h20766572, 32'h79207365, 32'h63726574, 32'h206d6573, 32'h73616765};
    for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    rand_mode = 1'b0;
    ready_val = 1'b1;
    wq.delete();
    base = done_cnt;
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL secret_armed start_at=%0d busy=%b in_ready=%b required 1 1", start_at, busy, in_ready);
    end
    send_msg(24, start_at);
    wait_done(200);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != 6) begin
      errors++;
      $display("FAIL secret_word_count start_at=%0d got %0d required 6", start_at, wq.size());
    end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== wrec_t'({exp[i], 4'b1111, (i == 5)})) begin
        errors++;
        $display("FAIL secret_word%0d got d=%h k=%b l=%b required d=%h k=1111 l=%b",
                 i, wq[i].d, wq[i].k, wq[i].l, exp[i], (i == 5));
      end
    end
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL secret_done_pulses got %0d required 1", done_cnt - base);
    end
    checks++;
    if (done_cyc != last_acc_cyc + 1) begin
      errors++;
      $display("FAIL secret_done_timing got cycle %0d required %0d", done_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (byte_count !== 32'd24 || busy !== 1'b0) begin
      errors++;
      $display("FAIL secret_byte_count got %0d busy=%b required 24 busy=0", byte_count, busy);
    end
  endtask

  task automatic test_short_messages();
    rand_mode = 1'b0;
    ready_val = 1'b1;
    wq.delete();
    ffq.delete();
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21;
    do_start();
    send_msg(3, -1);
    wait_done(100);
    checks++;
    if (wq.size() != 1 || wq[0] !== wrec_t'({32'h48692100, 4'b1110, 1'b1})) begin
      errors++;
      $display("FAIL hi_word got n=%0d d=%h k=%b l=%b required n=1 d=48692100 k=1110 l=1",
               wq.size(), wq[0].d, wq[0].k, wq[0].l);
    end
    checks++;
    if (ffq.size() != 1 || ffq[0] !== 32'h486921FF) begin
      errors++;
      $display("FAIL hi_word_padff got n=%0d d=%h required n=1 d=486921ff", ffq.size(), ffq[0]);
    end
    checks++;
    if (byte_count !== 32'd3) begin
      errors++;
      $display("FAIL hi_byte_count got %0d required 3", byte_count);
    end
    wq.delete();
    ffq.delete();
    msg[0] = 8'h41;
    do_start();
    send_msg(1, -1);
    wait_done(100);
    checks++;
    if (wq.size() != 1 || wq[0] !== wrec_t'({32'h41000000, 4'b1000, 1'b1})) begin
      errors++;
      $display("FAIL single_byte_word got n=%0d d=%h k=%b l=%b required n=1 d=41000000 k=1000 l=1",
               wq.size(), wq[0].d, wq[0].k, wq[0].l);
    end
    checks++;
    if (ffq.size() != 1 || ffq[0] !== 32'h41FFFFFF) begin
      errors++;
      $display("FAIL single_byte_padff got n=%0d d=%h required n=1 d=41ffffff", ffq.size(), ffq[0]);
    end
  endtask

  task automatic test_backpressure();
    logic        leaked;
    logic [31:0] exp[3];
    exp = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    rand_mode = 1'b0;
    ready_val = 1'b0;
    wq.delete();
    do_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b0, 1'b0);
    in_data  = 8'h09;
    in_valid = 1'b1;
    leaked   = 1'b0;
    repeat (4) begin
      if (in_ready) leaked = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (leaked !== 1'b0 || byte_count !== 32'd8) begin
      errors++;
      $display("FAIL bp_stall got in_ready_seen=%b byte_count=%0d required 0 8", leaked, byte_count);
    end
    checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h01020304) begin
      errors++;
      $display("FAIL bp_head got v=%b d=%h required v=1 d=01020304", word_valid, word_data);
    end
    ready_val = 1'b1;
    for (int i = 8; i < 12; i++) send_byte(8'(i + 1), (i == 11), 1'b0);
    wait_done(100);
    checks++;
    if (wq.size() != 3) begin
      errors++;
      $display("FAIL bp_word_count got %0d required 3", wq.size());
    end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== wrec_t'({exp[i], 4'b1111, (i == 2)})) begin
        errors++;
        $display("FAIL bp_word%0d got d=%h k=%b l=%b required d=%h k=1111 l=%b",
                 i, wq[i].d, wq[i].k, wq[i].l, exp[i], (i == 2));
      end
    end
  endtask

  task automatic test_random_ready();
    int unsigned bad;
    logic [31:0] e;
    for (int i = 0; i < 37; i++) msg[i] = 8'(i + 1);
    wq.delete();
    stab_err  = 0;
    stall_cnt = 0;
    rand_mode = 1'b1;
    do_start();
    send_msg(37, -1);
    wait_done(2000);
    rand_mode = 1'b0;
    ready_val = 1'b1;
    checks++;
    if (wq.size() != 10) begin
      errors++;
      $display("FAIL rand_word_count got %0d required 10", wq.size());
    end
    bad = 0;
    for (int k = 0; k < 9 && k < wq.size(); k++) begin
      e = {8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3), 8'(4 * k + 4)};
      checks++;
      if (wq[k] !== wrec_t'({e, 4'b1111, 1'b0})) begin
        errors++;
        $display("FAIL rand_word%0d got d=%h k=%b l=%b required d=%h k=1111 l=0",
                 k, wq[k].d, wq[k].k, wq[k].l, e);
      end
    end
    if (wq.size() >= 10) begin
      checks++;
      if (wq[9] !== wrec_t'({32'h25000000, 4'b1000, 1'b1})) begin
        errors++;
        $display("FAIL rand_last_word got d=%h k=%b l=%b required d=25000000 k=1000 l=1",
                 wq[9].d, wq[9].k, wq[9].l);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL rand_hold_stable got %0d unstable stalls required 0 (stalls=%0d)", stab_err, stall_cnt);
    end
    checks++;
    if (byte_count !== 32'd37) begin
      errors++;
      $display("FAIL rand_byte_count got %0d required 37", byte_count);
    end
  endtask

  task automatic test_reset_mid();
    rand_mode = 1'b0;
    ready_val = 1'b1;
    msg[0] = 8'h56; msg[1] = 8'h65; msg[2] = 8'h72; msg[3] = 8'h79; msg[4] = 8'h20;
    do_start();
    for (int i = 0; i < 5; i++) send_byte(msg[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, word_valid, word_last, word_keep, word_data, busy, done} !== '0 || byte_count !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%b v=%b l=%b k=%b d=%h busy=%b done=%b cnt=%0d required all 0",
               in_ready, word_valid, word_last, word_keep, word_data, busy, done, byte_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21;
    do_start();
    send_msg(3, -1);
    wait_done(100);
    checks++;
    if (wq.size() != 1 || wq[0] !== wrec_t'({32'h48692100, 4'b1110, 1'b1})) begin
      errors++;
      $display("FAIL midreset_hi_word got n=%0d d=%h k=%b l=%b required n=1 d=48692100 k=1110 l=1",
               wq.size(), wq[0].d, wq[0].k, wq[0].l);
    end
    checks++;
    if (byte_count !== 32'd3) begin
      errors++;
      $display("FAIL midreset_byte_count got %0d required 3", byte_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_secret_message(-1);
    test_short_messages();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    test_secret_message(10);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
